// File: rtl/if_pkg.sv
// Shared types and defaults for the RV32I instruction-fetch stage.
package if_pkg;

   // Fetch-side handshake states: issue a request, wait for its data, or park data for a stalled ID.
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } if_state_e;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] PC_INC        = 32'd4;

   // Force a fetch target onto a word boundary.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and its memory.
interface instruction_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats bubble, stall holds the contents.
module if_id_reg
   import if_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        load,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        valid
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;

   // Choose the next IF/ID contents; an empty slot becomes a NOP bubble with PC 0.
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (flush) begin
         instr_d = NOP_INSTR;
         pc_d    = 32'd0;
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = load_instr;
         pc_d    = load_pc;
         valid_d = 1'b1;
      end else if (!stall) begin
         instr_d = NOP_INSTR;
         pc_d    = 32'd0;
         valid_d = 1'b0;
      end
   end

   // Register the IF/ID slot, clearing to a bubble on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= NOP_INSTR;
         pc_q    <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign instr = instr_q;
   assign pc    = pc_q;
   assign valid = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: fetch PC, single-outstanding imem handshake, wrong-path kill and IF/ID feed.
// Optional build macro IF_MISALIGN_TRAP_EN adds the sticky fetch_misalign output.
module instruction_fetch
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall_ID,
   input  logic                 redirect,
   input  logic [31:0]          redirect_pc,
   instruction_fetch_if.master  imem,
   output logic [31:0]          Instruction_ID,
   output logic [31:0]          PC_ID,
   output logic                 valid_ID
`ifdef IF_MISALIGN_TRAP_EN
   ,
   output logic                 fetch_misalign
`endif
);

   if_state_e   state_q, state_d;
   logic [31:0] pc_fetch_q, pc_fetch_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        kill_q, kill_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic        req;
   logic        load;
   logic [31:0] load_instr;
   logic [31:0] load_pc;
   logic [31:0] target_pc;
   logic        redirect_bad;
   logic        fetch_parked;

`ifdef IF_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;

   assign redirect_bad   = redirect && (redirect_pc[1:0] != 2'b00);
   assign fetch_parked   = misalign_q;
   assign target_pc      = redirect_pc;
   assign fetch_misalign = misalign_q;

   // A misaligned control-transfer target latches the trap flag until reset.
   always_comb begin
      misalign_d = misalign_q | redirect_bad;
   end

   // Sticky misalignment flag register.
   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end
`else
   assign redirect_bad = 1'b0;
   assign fetch_parked = 1'b0;
   assign target_pc    = align_pc(redirect_pc);
`endif

   assign req            = (state_q == FETCH) && !redirect && !reset && !fetch_parked;
   assign imem.imem_req  = req;
   assign imem.imem_addr = pc_fetch_q;

   // Next-state logic: redirect outranks everything, then the normal fetch/wait/hold flow.
   always_comb begin
      state_d      = state_q;
      pc_fetch_d   = pc_fetch_q;
      req_pc_d     = req_pc_q;
      kill_d       = kill_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      load         = 1'b0;
      load_instr   = imem.imem_rdata;
      load_pc      = req_pc_q;
      if (redirect) begin
         pc_fetch_d = target_pc;
         case (state_q)
            FETCH: begin
            end
            WAIT: begin
               if (imem.imem_rvalid) begin
                  state_d = FETCH;
                  kill_d  = 1'b0;
               end else begin
                  kill_d  = 1'b1;
               end
            end
            HOLD: begin
               state_d = FETCH;
            end
            default: begin
               state_d = FETCH;
            end
         endcase
         if (redirect_bad) begin
            state_d = FETCH;
            kill_d  = 1'b0;
         end
      end else begin
         case (state_q)
            FETCH: begin
               if (req && imem.imem_gnt) begin
                  req_pc_d   = pc_fetch_q;
                  pc_fetch_d = pc_fetch_q + PC_INC;
                  state_d    = WAIT;
               end
            end
            WAIT: begin
               if (imem.imem_rvalid) begin
                  state_d = FETCH;
                  if (kill_q) begin
                     kill_d = 1'b0;
                  end else if (!stall_ID) begin
                     load = 1'b1;
                  end else begin
                     hold_instr_d = imem.imem_rdata;
                     hold_pc_d    = req_pc_q;
                     state_d      = HOLD;
                  end
               end
            end
            HOLD: begin
               if (!stall_ID) begin
                  load       = 1'b1;
                  load_instr = hold_instr_q;
                  load_pc    = hold_pc_q;
                  state_d    = FETCH;
               end
            end
            default: begin
               state_d = FETCH;
            end
         endcase
      end
   end

   // Fetch-side state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FETCH;
         pc_fetch_q   <= RESET_PC;
         req_pc_q     <= 32'd0;
         kill_q       <= 1'b0;
         hold_instr_q <= 32'd0;
         hold_pc_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_fetch_q   <= pc_fetch_d;
         req_pc_q     <= req_pc_d;
         kill_q       <= kill_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall_ID),
      .flush      (redirect),
      .load       (load),
      .load_instr (load_instr),
      .load_pc    (load_pc),
      .instr      (Instruction_ID),
      .pc         (PC_ID),
      .valid      (valid_ID)
   );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch stage. Honours IF_MISALIGN_TRAP_EN when defined.
module tb_instruction_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall_id = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic [31:0] instruction_id;
   logic [31:0] pc_id;
   logic        valid_id;
`ifdef IF_MISALIGN_TRAP_EN
   logic        fetch_misalign;
`endif

   instruction_fetch_if bus ();

   instruction_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .stall_ID       (stall_id),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .imem           (bus),
      .Instruction_ID (instruction_id),
      .PC_ID          (pc_id),
      .valid_ID       (valid_id)
`ifdef IF_MISALIGN_TRAP_EN
      ,
      .fetch_misalign (fetch_misalign)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // memory-side state
   logic        s_pend = 1'b0;
   logic [31:0] s_addr = 32'd0;
   int          s_age = 0;
   int          s_lat = 1;
   int          lat_cfg = 1;
   logic        rand_mode = 1'b0;

   // behavioural model of the fetch stage
   logic        m_busy, m_killed, m_held, m_mis;
   logic [31:0] m_pc, m_inflight, m_held_i, m_held_pc;
   logic [31:0] m_instr, m_pcid;
   logic        m_valid;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic modelReset();
      m_busy = 0; m_killed = 0; m_held = 0; m_mis = 0;
      m_pc = 32'd0; m_inflight = 0; m_held_i = 0; m_held_pc = 0;
      m_instr = NOP; m_pcid = 0; m_valid = 0;
   endtask

   task automatic modelStep(input logic exp_req);
      logic        have;
      logic [31:0] ci, cp;
      logic        bad;
      have = 0; ci = 0; cp = 0; bad = 0;
      if (reset) begin
         modelReset();
      end else if (redirect) begin
`ifdef IF_MISALIGN_TRAP_EN
         bad  = (redirect_pc[1:0] != 2'b00);
         m_pc = redirect_pc;
`else
         m_pc = {redirect_pc[31:2], 2'b00};
`endif
         m_instr = NOP; m_pcid = 0; m_valid = 0;
         m_held = 0;
         if (m_busy) begin
            if (bus.imem_rvalid) begin
               m_busy = 0; m_killed = 0;
            end else begin
               m_killed = 1;
            end
         end
         if (bad) begin
            m_mis = 1; m_busy = 0; m_killed = 0;
         end
      end else begin
         if (exp_req && bus.imem_gnt) begin
            m_busy = 1; m_inflight = m_pc; m_pc = m_pc + 32'd4;
         end else if (m_busy && bus.imem_rvalid) begin
            m_busy = 0;
            if (m_killed) m_killed = 0;
            else begin
               have = 1; ci = bus.imem_rdata; cp = m_inflight;
            end
         end else if (m_held && !stall_id) begin
            have = 1; ci = m_held_i; cp = m_held_pc; m_held = 0;
         end
         if (have && stall_id) begin
            m_held = 1; m_held_i = ci; m_held_pc = cp;
         end else if (have) begin
            m_instr = ci; m_pcid = cp; m_valid = 1;
         end else if (!stall_id) begin
            m_instr = NOP; m_pcid = 0; m_valid = 0;
         end
      end
   endtask

   task automatic modelCompare();
      logic exp_req;
      exp_req = !reset && !redirect && !m_busy && !m_held && !m_mis;
      checkOutput("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
      checkOutput("imem_addr", bus.imem_addr, m_pc);
      checkOutput("Instruction_ID", instruction_id, m_instr);
      checkOutput("PC_ID", pc_id, m_pcid);
      checkOutput("valid_ID", {31'd0, valid_id}, {31'd0, m_valid});
`ifdef IF_MISALIGN_TRAP_EN
      checkOutput("fetch_misalign", {31'd0, fetch_misalign}, {31'd0, m_mis});
`endif
      modelStep(exp_req);
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic rd, input logic [31:0] rp);
      @(negedge clk);
      reset = r; stall_id = s; redirect = rd; redirect_pc = rp;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      if (r) s_pend = 1'b0;
      if (s_pend) begin
         s_age++;
         if (s_age >= s_lat) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memWord(s_addr);
            s_pend = 1'b0;
         end
      end else if (rand_mode && $urandom_range(0, 4) == 0) begin
         bus.imem_rvalid = 1'b1;
      end
      bus.imem_gnt = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.imem_req && bus.imem_gnt) begin
         s_pend = 1'b1; s_addr = bus.imem_addr; s_age = 0;
         s_lat  = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
      end
      modelCompare();
   endtask

   initial begin
      logic [31:0] rp;
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
      modelReset();
      $display("[TB] directed phase");
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      // k0..k8: straight-line fetch, then stall as PC 0x8 returns
      applyStimulus(0, 0, 0, 0);
      checkOutput("rst_req", {31'd0, bus.imem_req}, 32'd1);
      checkOutput("rst_addr", bus.imem_addr, 32'h0);
      checkOutput("rst_instr", instruction_id, NOP);
      checkOutput("rst_valid", {31'd0, valid_id}, 32'd0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("wait_req", {31'd0, bus.imem_req}, 32'd0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("pc0_valid", {31'd0, valid_id}, 32'd1);
      checkOutput("pc0_pc", pc_id, 32'h0);
      checkOutput("pc0_instr", instruction_id, memWord(32'h0));
      checkOutput("addr4", bus.imem_addr, 32'h4);
      applyStimulus(0, 0, 0, 0);
      checkOutput("bubble_valid", {31'd0, valid_id}, 32'd0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("pc4_pc", pc_id, 32'h4);
      checkOutput("pc4_valid", {31'd0, valid_id}, 32'd1);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("hold_req", {31'd0, bus.imem_req}, 32'd0);
      checkOutput("hold_instr", instruction_id, NOP);
      applyStimulus(0, 0, 0, 0);
      checkOutput("hold_valid", {31'd0, valid_id}, 32'd0);
      lat_cfg = 3;
      applyStimulus(0, 0, 0, 0);
      checkOutput("pc8_pc", pc_id, 32'h8);
      checkOutput("pc8_instr", instruction_id, memWord(32'h8));
      checkOutput("pc8_valid", {31'd0, valid_id}, 32'd1);
      // redirect in WAIT, response two cycles later is dropped
      applyStimulus(0, 0, 1, 32'h100);
      applyStimulus(0, 0, 0, 0);
      checkOutput("kill_instr", instruction_id, NOP);
      applyStimulus(0, 0, 0, 0);
      checkOutput("kill_req", {31'd0, bus.imem_req}, 32'd0);
      lat_cfg = 1;
      applyStimulus(0, 0, 0, 0);
      checkOutput("redir_addr", bus.imem_addr, 32'h100);
      checkOutput("redir_req", {31'd0, bus.imem_req}, 32'd1);
      checkOutput("redir_valid", {31'd0, valid_id}, 32'd0);
      // redirect coincident with rvalid
      applyStimulus(0, 0, 1, 32'h200);
      applyStimulus(0, 0, 0, 0);
      checkOutput("same_addr", bus.imem_addr, 32'h200);
      checkOutput("same_req", {31'd0, bus.imem_req}, 32'd1);
      // redirect while held in HOLD
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 1, 32'h300);
      checkOutput("holdredir_req", {31'd0, bus.imem_req}, 32'd0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("holdredir_addr", bus.imem_addr, 32'h300);
      checkOutput("holdredir_valid", {31'd0, valid_id}, 32'd0);
      checkOutput("holdredir_instr", instruction_id, NOP);

      $display("[TB] random phase");
      rand_mode = 1'b1; lat_cfg = 0;
      for (int i = 0; i < 3000; i++) begin
`ifdef IF_MISALIGN_TRAP_EN
         rp = $urandom & 32'h0000_0FFC;
`else
         rp = $urandom & 32'h0000_0FFF;
`endif
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 3,
                       $urandom_range(0, 9) == 0, rp);
      end

`ifdef IF_MISALIGN_TRAP_EN
      $display("[TB] misalign phase");
      rand_mode = 1'b0; lat_cfg = 1;
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 1, 32'h102);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, i == 2, 32'h200);
         checkOutput("mis_flag", {31'd0, fetch_misalign}, 32'd1);
         checkOutput("mis_req", {31'd0, bus.imem_req}, 32'd0);
      end
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("mis_cleared", {31'd0, fetch_misalign}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
